avalon_mm_rmw_sweep_master: RTL
===============================

Name: avalon_mm_rmw_sweep_master

Overview:
- Parametrised Avalon-MM master that, every INTERVAL cycles, sweeps NUM_WORDS consecutive words from BASE_ADDR.
- For each word it reads the value, adds STEP and writes the result back; zero-valued words are left untouched.
- Successor to the single-register increment master. Adds an address bus, full waitrequest/readdatavalid compliance, configurable width, depth and step, and status outputs.
- Sits on the FPGA-side Avalon fabric next to the HPS-shared memory it maintains.

Parameters:
- DATA_W, 32, data bus width; must be a multiple of 8.
- ADDR_W, 32, byte-address width.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_W/8.
- NUM_WORDS, 4, words per sweep; minimum 1.
- INTERVAL, 100, idle cycles between sweeps; minimum 1.
- STEP, 1, increment added to each non-zero word.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, reset.
- enable, in, 1, permits new sweeps to start.
- address, out, ADDR_W, byte address of the current access.
- byteenable, out, DATA_W/8, all ones during an access, zero otherwise.
- read, out, 1, Avalon read request.
- readdata, in, DATA_W, read data.
- readdatavalid, in, 1, read data qualifier.
- write, out, 1, Avalon write request.
- writedata, out, DATA_W, write data.
- waitrequest, in, 1, slave stall.
- busy, out, 1, high from sweep start until the last word completes.
- sweep_count, out, 16, number of completed sweeps; wraps at 16 bits.

Behaviour:
- Interface (already decided): one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: all outputs registered; all clear to 0; address = BASE_ADDR. Assertion mid-transaction aborts immediately, with read/write dropped asynchronously.
- State machine: IDLE, RD_REQ, RD_WAIT, WR_REQ, ADVANCE.
- IDLE:
  - Interval counter increments while enable=1 and holds while enable=0.
  - When counter = INTERVAL-1: counter clears, index clears, address = BASE_ADDR, busy=1, next state RD_REQ.
- RD_REQ:
  - read=1, byteenable all ones.
  - Held stable while waitrequest=1.
  - On the first cycle with waitrequest=0, read drops next cycle and the state goes to RD_WAIT.
- RD_WAIT:
  - Waits for readdatavalid=1 and captures readdata.
  - If readdatavalid is already high in the acceptance cycle, the data is captured there and RD_WAIT is skipped.
  - Captured value 0: go to ADVANCE with no write.
  - Otherwise: writedata = captured + STEP, truncated to DATA_W (wraps modulo 2^DATA_W), then go to WR_REQ.
- WR_REQ:
  - write=1, byteenable all ones, address and writedata held stable while waitrequest=1.
  - On the cycle with waitrequest=0, write drops next cycle and the state goes to ADVANCE.
- ADVANCE:
  - If index = NUM_WORDS-1: busy=0, sweep_count increments, go to IDLE.
  - Otherwise: index increments, address += DATA_W/8, go to RD_REQ.
- Bus rules:
  - read and write are never asserted together.
  - At most one read outstanding.
  - byteenable is 0 whenever read=write=0.
- Boundary and timing rules:
  - enable dropping mid-sweep does not abort the sweep; it only stops the next one from starting.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - Minimum per word with zero wait states: read accept 1 + data 1 + write 1 + advance 1 = 4 cycles.
  - A spurious readdatavalid outside RD_REQ/RD_WAIT is ignored.

Optional Feature:
- Macro: RMW_SATURATE_EN.
- Defined: increment saturates; if captured + STEP exceeds all-ones, writedata = all-ones. A word already at all-ones is still rewritten as all-ones.
- Undefined: modulo wrap as described under Behaviour.

Test Plan:
- Default params, memory model preloaded with {5, 0, 0xFFFFFFFF, 7}, zero wait states, enable=1:
  - After 100 idle cycles, reads occur at 0x0, 0x4, 0x8, 0xC.
  - Writes occur to 0x0 = 6, 0x8 = 0 (wrap), 0xC = 8; no write to 0x4.
  - sweep_count = 1, busy high for the whole sweep.
- Same as above with RMW_SATURATE_EN defined -> 0x8 written as 0xFFFFFFFF; other results unchanged.
- waitrequest held high 3 cycles on every access -> read/write/address/writedata stable throughout the stall; each asserted exactly 1 cycle after waitrequest drops; memory contents match the zero-wait case.
- readdatavalid delayed 5 cycles after read accept -> no write issued before data arrives; correct increment written; read never re-asserted while waiting.
- enable=0 after the first sweep starts -> sweep completes (sweep_count=1); no second sweep within 500 cycles; re-asserting enable starts the next sweep 100 cycles later.
- reset_n pulsed low during WR_REQ of word 2 -> write drops immediately; all outputs at reset values; after release, the next sweep restarts at BASE_ADDR; sweep_count=0.

Source files
------------

// File: rtl/avalon_mm_rmw_sweep_master.sv
// Avalon-MM master that periodically sweeps NUM_WORDS words, adding STEP to every non-zero word.
// Optional macro RMW_SATURATE_EN: saturate the increment at all-ones instead of wrapping.
module avalon_mm_rmw_sweep_master #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        NUM_WORDS = 4,
    parameter int unsigned        INTERVAL  = 100,
    parameter logic [DATA_W-1:0]  STEP      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                read,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                readdatavalid,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    input  logic                waitrequest,
    output logic                busy,
    output logic [15:0]         sweep_count
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(BE_W);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, ADVANCE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic [BE_W-1:0]    byteenable_q, byteenable_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  writedata_q, writedata_d;
    logic               busy_q, busy_d;
    logic [15:0]        sweep_count_q, sweep_count_d;
    logic               capture;

    function automatic logic [DATA_W-1:0] rmw_incr(input logic [DATA_W-1:0] value);
`ifdef RMW_SATURATE_EN
        logic [DATA_W:0] sum;
        sum = {1'b0, value} + {1'b0, STEP};
        rmw_incr = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        rmw_incr = value + STEP;
`endif
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        busy_d        = busy_q;
        sweep_count_d = sweep_count_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d     = '0;
                        idx_d     = '0;
                        address_d = BASE_ADDR;
                        busy_d    = 1'b1;
                        read_d    = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RD_REQ: begin
                if (!waitrequest) begin
                    read_d = 1'b0;
                    // Data returned in the acceptance cycle skips RD_WAIT entirely.
                    if (readdatavalid) begin
                        capture = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (readdatavalid) begin
                    capture = 1'b1;
                end
            end
            WR_REQ: begin
                if (!waitrequest) begin
                    write_d = 1'b0;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (idx_q == LAST_IDX) begin
                    busy_d        = 1'b0;
                    sweep_count_d = sweep_count_q + 16'd1;
                    state_d       = IDLE;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    address_d = address_q + WORD_BYTES;
                    read_d    = 1'b1;
                    state_d   = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Zero words are skipped without a write so untouched memory stays untouched.
        if (capture) begin
            if (readdata == '0) begin
                state_d = ADVANCE;
            end else begin
                writedata_d = rmw_incr(readdata);
                write_d     = 1'b1;
                state_d     = WR_REQ;
            end
        end

        byteenable_d = (read_d || write_d) ? '1 : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            address_q     <= BASE_ADDR;
            byteenable_q  <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= '0;
            busy_q        <= 1'b0;
            sweep_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            address_q     <= address_d;
            byteenable_q  <= byteenable_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            busy_q        <= busy_d;
            sweep_count_q <= sweep_count_d;
        end
    end

    assign address     = address_q;
    assign byteenable  = byteenable_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign busy        = busy_q;
    assign sweep_count = sweep_count_q;

endmodule
